key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/clock_pkg.sv | 29 ++
 rtl/key_debounce.sv | 123 ++++++++++++
 rtl/key_conditioner.sv | 93 +++++++++
 tb/tb_key_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared clock constants, default debounce/repeat timing and key channel indices
// for the front-panel key conditioner.
package clock_pkg;

    localparam int CLK_HZ     = 48_000_000;
    localparam int CYC_PER_MS = CLK_HZ / 1000;

    localparam int DB_MS         = 20;
    localparam int RPT_DELAY_MS  = 500;
    localparam int RPT_PERIOD_MS = 100;

    localparam int DB_CYC_DEFAULT     = DB_MS * CYC_PER_MS;
    localparam int RPT_DELAY_DEFAULT  = RPT_DELAY_MS * CYC_PER_MS;
    localparam int RPT_PERIOD_DEFAULT = RPT_PERIOD_MS * CYC_PER_MS;

    // Channel order inside the conditioner; adjust channels come first.
    localparam int NUM_KEYS  = 5;
    localparam int NUM_ADJ   = 3;
    localparam int KEY_SEC   = 0;
    localparam int KEY_MIN   = 1;
    localparam int KEY_HOUR  = 2;
    localparam int KEY_CLEAR = 3;
    localparam int KEY_KEEP  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-FF synchronizer, debounce counter with debounced state,
// press/release event pulses and an optional hold-to-repeat timer.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DB_CYC     = DB_CYC_DEFAULT,
    parameter int RPT_DELAY  = RPT_DELAY_DEFAULT,
    parameter int RPT_PERIOD = RPT_PERIOD_DEFAULT,
    parameter bit REPEAT_EN  = 1'b0
) (
    input  logic clk_48mhz,
    input  logic rst,
    input  logic key_n,
    output logic stable,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W = $clog2(DB_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

    logic sync1_q;
    logic sync2_q;
    logic stable_q;
    logic stable_d;
    logic press_q;
    logic press_d;
    logic release_q;
    logic release_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // The counter only advances while the synchronized level disagrees with stable.
    always_comb begin
        stable_d  = stable_q;
        db_cnt_d  = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d  = sync2_q;
                press_d   = sync2_q;
                release_d = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= ~key_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign stable        = stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

    generate
        if (REPEAT_EN) begin : g_rpt
            localparam int RPT_W = $clog2(max_int(RPT_DELAY, RPT_PERIOD) + 1);
            localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(RPT_DELAY - 1);
            localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(RPT_PERIOD - 1);

            logic [RPT_W-1:0] rpt_cnt_q;
            logic [RPT_W-1:0] rpt_cnt_d;
            logic             first_q;
            logic             first_d;
            logic             rpt_q;
            logic             rpt_d;

            // Timer restarts on press and is held at zero unless the key stays down
            // across this edge, so a release edge can never produce a repeat.
            always_comb begin
                rpt_cnt_d = '0;
                first_d   = 1'b0;
                rpt_d     = 1'b0;
                if (press_d) begin
                    first_d = 1'b1;
                end else if (stable_q && stable_d) begin
                    first_d = first_q;
                    if (rpt_cnt_q == (first_q ? DLY_LAST : PER_LAST)) begin
                        rpt_d   = 1'b1;
                        first_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_48mhz) begin
                if (rst) begin
                    rpt_cnt_q <= '0;
                    first_q   <= 1'b0;
                    rpt_q     <= 1'b0;
                end else begin
                    rpt_cnt_q <= rpt_cnt_d;
                    first_q   <= first_d;
                    rpt_q     <= rpt_d;
                end
            end

            assign repeat_pulse = rpt_q;
        end else begin : g_no_rpt
            assign repeat_pulse = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/key_conditioner.sv
// Front-panel key conditioner: debounces five buttons, produces adjust strobes
// with auto-repeat, a clear level and a keep (pause) toggle that clear overrides.
module key_conditioner
    import clock_pkg::*;
#(
    parameter int DB_CYC     = DB_CYC_DEFAULT,
    parameter int RPT_DELAY  = RPT_DELAY_DEFAULT,
    parameter int RPT_PERIOD = RPT_PERIOD_DEFAULT
) (
    input  logic clk_48mhz,
    input  logic rst,
    input  logic key_sec_n,
    input  logic key_min_n,
    input  logic key_hour_n,
    input  logic key_clear_n,
    input  logic key_keep_n,
    output logic adjust_sec,
    output logic adjust_min,
    output logic adjust_hour,
    output logic clear,
    output logic keep
);

    logic [NUM_KEYS-1:0] keys_n;
    logic [NUM_KEYS-1:0] stable_w;
    logic [NUM_KEYS-1:0] press_w;
    logic [NUM_KEYS-1:0] release_w;
    logic [NUM_KEYS-1:0] repeat_w;

    assign keys_n = {key_keep_n, key_clear_n, key_hour_n, key_min_n, key_sec_n};

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DB_CYC     (DB_CYC),
                .RPT_DELAY  (RPT_DELAY),
                .RPT_PERIOD (RPT_PERIOD),
                .REPEAT_EN  (gi < NUM_ADJ)
            ) u_debounce (
                .clk_48mhz     (clk_48mhz),
                .rst           (rst),
                .key_n         (keys_n[gi]),
                .stable        (stable_w[gi]),
                .press_pulse   (press_w[gi]),
                .release_pulse (release_w[gi]),
                .repeat_pulse  (repeat_w[gi])
            );
        end
    endgenerate

    logic [NUM_ADJ-1:0] adjust_q;
    logic [NUM_ADJ-1:0] adjust_d;
    logic               clear_q;
    logic               clear_d;
    logic               keep_q;
    logic               keep_d;

    // Clear press is applied after the keep toggle so that it wins on a tie.
    always_comb begin
        adjust_d = press_w[NUM_ADJ-1:0] | repeat_w[NUM_ADJ-1:0];
        clear_d  = stable_w[KEY_CLEAR];
        keep_d   = keep_q;
        if (press_w[KEY_KEEP]) begin
            keep_d = ~keep_q;
        end
        if (press_w[KEY_CLEAR]) begin
            keep_d = 1'b0;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (rst) begin
            adjust_q <= '0;
            clear_q  <= 1'b0;
            keep_q   <= 1'b0;
        end else begin
            adjust_q <= adjust_d;
            clear_q  <= clear_d;
            keep_q   <= keep_d;
        end
    end

    assign adjust_sec  = adjust_q[KEY_SEC];
    assign adjust_min  = adjust_q[KEY_MIN];
    assign adjust_hour = adjust_q[KEY_HOUR];
    assign clear       = clear_q;
    assign keep        = keep_q;

    logic unused_evt;
    assign unused_evt = ^{stable_w[KEY_KEEP], stable_w[NUM_ADJ-1:0], release_w,
                          repeat_w[NUM_KEYS-1:NUM_ADJ]};

endmodule

// File: tb/tb_key_conditioner.sv
// Randomized and directed bench for key_conditioner against a behavioural
// model built from debounce run lengths and hold ages.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] keys_n;
    logic       adjust_sec, adjust_min, adjust_hour, clear, keep;
    logic [4:0] dut_vec;

    assign dut_vec = {keep, clear, adjust_hour, adjust_min, adjust_sec};

    always #5 clk = ~clk;

    key_conditioner #(
        .DB_CYC     (DB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .clk_48mhz   (clk),
        .rst         (rst),
        .key_sec_n   (keys_n[0]),
        .key_min_n   (keys_n[1]),
        .key_hour_n  (keys_n[2]),
        .key_clear_n (keys_n[3]),
        .key_keep_n  (keys_n[4]),
        .adjust_sec  (adjust_sec),
        .adjust_min  (adjust_min),
        .adjust_hour (adjust_hour),
        .clear       (clear),
        .keep        (keep)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Behavioural model: debounced level from run length of disagreement,
    // repeats from the age of the current hold.
    bit       m_sync1[5], m_sync2[5], m_stable[5], m_press[5], m_rpt[5];
    int       m_run[5], m_age[5];
    bit [2:0] m_adj;
    bit       m_clear, m_keep;

    function automatic logic [4:0] model_vec();
        return {m_keep, m_clear, m_adj};
    endfunction

    task automatic model_step(input logic r, input logic [4:0] kn);
        bit [2:0] adj_next;
        bit       clear_next, keep_next;
        if (r) begin
            for (int c = 0; c < 5; c++) begin
                m_sync1[c] = 0; m_sync2[c] = 0; m_stable[c] = 0;
                m_press[c] = 0; m_rpt[c] = 0; m_run[c] = 0; m_age[c] = 0;
            end
            m_adj = 0; m_clear = 0; m_keep = 0;
            return;
        end
        for (int c = 0; c < 3; c++) adj_next[c] = m_press[c] | m_rpt[c];
        clear_next = m_stable[3];
        keep_next  = m_press[3] ? 1'b0 : (m_press[4] ? !m_keep : m_keep);
        for (int c = 0; c < 5; c++) begin
            bit was, pr;
            was = m_stable[c];
            pr  = 0;
            if (m_sync2[c] != m_stable[c]) begin
                m_run[c]++;
                if (m_run[c] == DB) begin
                    m_stable[c] = m_sync2[c];
                    m_run[c]    = 0;
                    pr          = m_stable[c];
                end
            end else begin
                m_run[c] = 0;
            end
            if (pr) m_age[c] = 0;
            else if (was && m_stable[c]) m_age[c]++;
            else m_age[c] = 0;
            m_rpt[c]   = (c < 3) && was && m_stable[c] && (m_age[c] >= RD) &&
                         (((m_age[c] - RD) % RP) == 0);
            m_press[c] = pr;
            m_sync2[c] = m_sync1[c];
            m_sync1[c] = !kn[c];
        end
        m_adj = adj_next; m_clear = clear_next; m_keep = keep_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, keys_n);
        @(negedge clk);
        check_eq("outputs", 32'(dut_vec), 32'(model_vec()));
    endtask

    task automatic idle(input int n);
        keys_n = '1;
        repeat (n) tick();
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        check_eq({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            check_eq(tag, (k < got.size()) ? 32'(got[k]) : 32'hffff_ffff, 32'(exp[k]));
    endtask

    initial begin
        int hits;
        int got_q[$];
        int exp_q[$];
        int run_left[5];
        int n_strobe;

        rst = 1'b1;
        keys_n = '1;
        repeat (3) tick();
        check_eq("reset_outs", 32'(dut_vec), 32'd0);
        rst = 1'b0;
        idle(5);
        $display("reset: outputs %b", dut_vec);

        hits = 0;
        for (int t = 1; t <= 25; t++) begin
            keys_n[0] = (t <= 3) ? 1'b0 : 1'b1;
            tick();
            if (dut_vec != 5'd0) hits++;
        end
        check_eq("glitch_outputs", 32'(hits), 32'd0);
        $display("glitch: %0d active output cycles", hits);
        idle(10);

        got_q.delete();
        for (int t = 1; t <= 74; t++) begin
            keys_n[1] = (t <= 44) ? 1'b0 : 1'b1;
            tick();
            if (adjust_min) got_q.push_back(t);
        end
        exp_q = '{7, 27, 35, 43};
        check_list("min_hold_strobes", got_q, exp_q);
        $display("hold min: %0d strobes", got_q.size());
        idle(10);

        got_q.delete();
        for (int t = 1; t <= 60; t++) begin
            keys_n[2] = (t <= 36 && t != 15 && t != 16) ? 1'b0 : 1'b1;
            tick();
            if (adjust_hour) got_q.push_back(t);
        end
        exp_q = '{7, 27, 35};
        check_list("hour_bounce_strobes", got_q, exp_q);
        $display("bounce hour: %0d strobes", got_q.size());
        idle(10);

        for (int p = 0; p < 2; p++) begin
            for (int t = 1; t <= 25; t++) begin
                keys_n[4] = (t <= 10) ? 1'b0 : 1'b1;
                tick();
                if (t == 6)  check_eq("keep_before_toggle", 32'(keep), 32'(p));
                if (t == 7)  check_eq("keep_toggle", 32'(keep), 32'(1 - p));
                if (t == 25) check_eq("keep_after_release", 32'(keep), 32'(1 - p));
            end
            $display("keep press %0d: keep=%0b", p + 1, keep);
        end

        for (int t = 1; t <= 25; t++) begin
            keys_n[4] = (t <= 10) ? 1'b0 : 1'b1;
            tick();
        end
        check_eq("prio_keep_set", 32'(keep), 32'd1);
        for (int t = 1; t <= 12; t++) begin
            keys_n[3] = 1'b0;
            keys_n[4] = 1'b0;
            tick();
            if (t == 6) check_eq("prio_clear_early", 32'(clear), 32'd0);
            if (t == 7) begin
                check_eq("prio_clear_rise", 32'(clear), 32'd1);
                check_eq("prio_keep_forced", 32'(keep), 32'd0);
            end
        end
        for (int t = 1; t <= 15; t++) begin
            keys_n = '1;
            tick();
            if (t == 6)  check_eq("clear_still_high", 32'(clear), 32'd1);
            if (t == 7)  check_eq("clear_fall", 32'(clear), 32'd0);
            if (t == 15) check_eq("prio_keep_after", 32'(keep), 32'd0);
        end
        $display("priority: clear=%0b keep=%0b", clear, keep);
        idle(5);

        got_q.delete();
        for (int t = 1; t <= 80; t++) begin
            rst = (t == 31) ? 1'b1 : 1'b0;
            keys_n[0] = (t <= 66) ? 1'b0 : 1'b1;
            tick();
            if (t == 31) check_eq("rst_mid_hold_outs", 32'(dut_vec), 32'd0);
            if (adjust_sec) got_q.push_back(t);
        end
        rst = 1'b0;
        exp_q = '{7, 27, 38, 58, 66};
        check_list("rst_hold_strobes", got_q, exp_q);
        $display("reset mid-hold: %0d strobes", got_q.size());
        idle(10);

        n_strobe = 0;
        for (int c = 0; c < 5; c++) run_left[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (run_left[c] == 0) begin
                    keys_n[c]   = ~keys_n[c];
                    run_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB + 1))
                                                               : int'($urandom_range(DB + 2, 60));
                end
                run_left[c]--;
            end
            tick();
            n_strobe += int'(adjust_sec) + int'(adjust_min) + int'(adjust_hour);
        end
        rst = 1'b0;
        $display("random: 4000 cycles, %0d adjust strobes", n_strobe);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
